// File: rtl/inv_roundkeygen_if.sv
// ------------------------------------------------------------------
// inv_roundkeygen_if : key load / round-key stream bundle for inv_roundkeygen
// Revision: 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface inv_roundkeygen_if;
   logic [255:0] key_last;
   logic         start;
   logic [127:0] round_key_out;
   logic         round_key_valid;
   logic         busy;
   logic         done;

   modport master (
      output key_last,
      output start,
      input  round_key_out,
      input  round_key_valid,
      input  busy,
      input  done
   );

   modport slave (
      input  key_last,
      input  start,
      output round_key_out,
      output round_key_valid,
      output busy,
      output done
   );
endinterface

`default_nettype wire

// File: rtl/inv_roundkeygen.sv
// ------------------------------------------------------------------
// inv_roundkeygen : AES-256 inverse key expansion, emits RK14 down to RK0
// Revision: 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module inv_roundkeygen (
   input wire               clk,
   input wire               rst_n,
   inv_roundkeygen_if.slave bus
);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [5:0] FIRST_INDEX = 6'd52;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      EXPAND = 1'b1
   } state_t;

   // Byte 0x00 sits in the top byte of the table, so the lookup index is inverted.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] x);
      return {x[23:0], x[31:24]};
   endfunction

   function automatic logic [7:0] rcon(input logic [2:0] n);
      logic [7:0] r;
      case (n)
         3'd1:    r = 8'h01;
         3'd2:    r = 8'h02;
         3'd3:    r = 8'h04;
         3'd4:    r = 8'h08;
         3'd5:    r = 8'h10;
         3'd6:    r = 8'h20;
         3'd7:    r = 8'h40;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   state_t           state;
   state_t           state_nxt;
   logic [7:0][31:0] win;         // win[k] = w[idx+k]
   logic [7:0][31:0] load_win;
   logic [5:0]       idx;
   logic [5:0]       j;
   logic [31:0]      f_word;
   logic [31:0]      new_word;
   logic [127:0]     rk;
   logic             rk_valid;
   logic             done_q;

   logic             load;
   logic             step;
   logic             emit;
   logic             finish;
   logic [127:0]     emit_key;

   for (genvar g = 0; g < 8; g++) begin : g_load
      assign load_win[g] = bus.key_last[32*(7-g) +: 32];
   end

   assign j = idx + 6'd7;

   always_comb begin
      f_word = win[6];
      case (j[2:0])
         3'd0:    f_word = sub_word(rot_word(win[6])) ^ {rcon(j[5:3]), 24'h000000};
         3'd4:    f_word = sub_word(win[6]);
         default: f_word = win[6];
      endcase
   end

   assign new_word = win[7] ^ f_word;

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      emit      = 1'b0;
      finish    = 1'b0;
      emit_key  = rk;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = EXPAND;
               load      = 1'b1;
            end
         end
         EXPAND: begin
            if (idx == 6'd0) begin
               state_nxt = IDLE;
               finish    = 1'b1;
            end else begin
               step = 1'b1;
            end
            // RK14 and RK13 come straight from the loaded window; the rest follow every 4th word.
            if (idx == FIRST_INDEX) begin
               emit     = 1'b1;
               emit_key = {win[4], win[5], win[6], win[7]};
            end else if (idx == FIRST_INDEX - 6'd1) begin
               emit     = 1'b1;
               emit_key = {win[1], win[2], win[3], win[4]};
            end else if (idx[1:0] == 2'b00) begin
               emit     = 1'b1;
               emit_key = {win[0], win[1], win[2], win[3]};
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         win      <= '0;
         idx      <= '0;
         rk       <= '0;
         rk_valid <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         rk_valid <= emit;
         done_q   <= finish;
         if (emit) begin
            rk <= emit_key;
         end
         if (load) begin
            win <= load_win;
            idx <= FIRST_INDEX;
         end else if (step) begin
            win <= {win[6:0], new_word};
            idx <= idx - 6'd1;
         end
      end
   end

   assign bus.round_key_out   = rk;
   assign bus.round_key_valid = rk_valid;
   assign bus.busy            = (state == EXPAND);
   assign bus.done            = done_q;

endmodule

`default_nettype wire

// File: tb/tb_inv_roundkeygen.sv
// ------------------------------------------------------------------
// tb_inv_roundkeygen : directed and round-trip bench for inv_roundkeygen
// Revision: 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_inv_roundkeygen;

   localparam int NCAP = 56;
   localparam logic [2047:0] SBOX_TB = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic clk = 1'b0;
   logic rst_n;
   int   tests_run = 0;
   int   tests_failed = 0;

   inv_roundkeygen_if bus();

   inv_roundkeygen dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [31:0]  fw        [0:59];
   logic [127:0] cap_key   [0:NCAP];
   logic         cap_valid [0:NCAP];
   logic         cap_busy  [0:NCAP];
   logic         cap_done  [0:NCAP];
   logic [127:0] seq       [0:15];
   int           seq_n;

   function automatic logic [7:0] tb_sbox(input logic [7:0] x);
      int p;
      p = 255 - int'(x);
      return SBOX_TB[p*8 +: 8];
   endfunction

   function automatic logic [31:0] tb_sub(input logic [31:0] x);
      return {tb_sbox(x[31:24]), tb_sbox(x[23:16]), tb_sbox(x[15:8]), tb_sbox(x[7:0])};
   endfunction

   // Forward AES-256 key schedule into fw[0..59].
   task automatic forward_expand(input logic [255:0] key);
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int k = 0; k < 8; k++) fw[k] = key[255-32*k -: 32];
      for (int k = 8; k < 60; k++) begin
         t = fw[k-1];
         if (k % 8 == 0) begin
            t  = tb_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (k % 8 == 4) begin
            t = tb_sub(t);
         end
         fw[k] = fw[k-8] ^ t;
      end
   endtask

   function automatic logic [127:0] exp_rk(input int r);
      return {fw[4*r], fw[4*r+1], fw[4*r+2], fw[4*r+3]};
   endfunction

   function automatic logic [255:0] fw_last();
      return {fw[52], fw[53], fw[54], fw[55], fw[56], fw[57], fw[58], fw[59]};
   endfunction

   function automatic logic [255:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start at E0, then record edges E1..E56; extra start pulses at edges a and b.
   task automatic run_capture(input logic [255:0] key, input int a, input int b,
                              input logic [255:0] alt_key);
      bus.key_last = key;
      bus.start    = 1'b1;
      tick();
      cap_busy[0] = bus.busy;
      for (int n = 1; n <= NCAP; n++) begin
         bus.start    = (n == a) || (n == b);
         bus.key_last = (n == a) ? alt_key : key;
         tick();
         cap_key[n]   = bus.round_key_out;
         cap_valid[n] = bus.round_key_valid;
         cap_busy[n]  = bus.busy;
         cap_done[n]  = bus.done;
      end
      bus.start    = 1'b0;
      bus.key_last = key;
   endtask

   task automatic gather();
      seq_n = 0;
      for (int k = 0; k < 16; k++) seq[k] = '0;
      for (int n = 1; n <= NCAP; n++) begin
         if (cap_valid[n] === 1'b1) begin
            if (seq_n < 16) seq[seq_n] = cap_key[n];
            seq_n++;
         end
      end
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.key_last = '0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (bus.round_key_out !== 128'h0) begin
         tests_failed++;
         $display("FAIL reset_rk: got %h want 0", bus.round_key_out);
      end
      tests_run++;
      if (bus.round_key_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_valid: got %b want 0", bus.round_key_valid);
      end
      tests_run++;
      if (bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_busy: got %b want 0", bus.busy);
      end
      tests_run++;
      if (bus.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_done: got %b want 0", bus.done);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fips_c3();
      logic [127:0] want [0:3];
      int           edge_at [0:3];
      want[0] = 128'h24fc79ccbf0979e9371ac23c6d68de36; edge_at[0] = 1;
      want[1] = 128'h4e5a6699a9f24fe07e572baacdf8cdea; edge_at[1] = 2;
      want[2] = 128'h101112131415161718191a1b1c1d1e1f; edge_at[2] = 49;
      want[3] = 128'h000102030405060708090a0b0c0d0e0f; edge_at[3] = 53;
      run_capture(256'h4e5a6699a9f24fe07e572baacdf8cdea_24fc79ccbf0979e9371ac23c6d68de36,
                  0, 0, '0);
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (cap_valid[edge_at[k]] !== 1'b1 || cap_key[edge_at[k]] !== want[k]) begin
            tests_failed++;
            $display("FAIL fips_E%0d: got valid=%b key=%h want valid=1 key=%h",
                     edge_at[k], cap_valid[edge_at[k]], cap_key[edge_at[k]], want[k]);
         end
      end
      tests_run++;
      if (cap_done[53] !== 1'b1) begin
         tests_failed++;
         $display("FAIL fips_done_E53: got %b want 1", cap_done[53]);
      end
      forward_expand(256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f);
      gather();
      for (int k = 0; k < 15; k++) begin
         tests_run++;
         if (seq[k] !== exp_rk(14 - k)) begin
            tests_failed++;
            $display("FAIL fips_seq_rk%0d: got %h want %h", 14 - k, seq[k], exp_rk(14 - k));
         end
      end
   endtask

   task automatic test_timing();
      logic         exp_v;
      logic [127:0] last;
      forward_expand(rand_key());
      run_capture(fw_last(), 0, 0, '0);
      tests_run++;
      if (cap_busy[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL timing_busy_E0: got %b want 1", cap_busy[0]);
      end
      last = '0;
      for (int n = 1; n <= NCAP; n++) begin
         exp_v = (n == 1) || (n == 2) || (n >= 5 && n <= 53 && (n - 1) % 4 == 0);
         tests_run++;
         if (cap_valid[n] !== exp_v) begin
            tests_failed++;
            $display("FAIL timing_valid_E%0d: got %b want %b", n, cap_valid[n], exp_v);
         end
         tests_run++;
         if (cap_busy[n] !== (n <= 52)) begin
            tests_failed++;
            $display("FAIL timing_busy_E%0d: got %b want %b", n, cap_busy[n], (n <= 52));
         end
         tests_run++;
         if (cap_done[n] !== (n == 53)) begin
            tests_failed++;
            $display("FAIL timing_done_E%0d: got %b want %b", n, cap_done[n], (n == 53));
         end
         if (exp_v) begin
            last = cap_key[n];
         end else if (n > 1) begin
            tests_run++;
            if (cap_key[n] !== last) begin
               tests_failed++;
               $display("FAIL timing_hold_E%0d: got %h want %h", n, cap_key[n], last);
            end
         end
      end
   endtask

   task automatic test_round_trip();
      for (int it = 0; it < 20; it++) begin
         forward_expand(rand_key());
         run_capture(fw_last(), 0, 0, '0);
         gather();
         tests_run++;
         if (seq_n !== 15) begin
            tests_failed++;
            $display("FAIL roundtrip_count_%0d: got %0d want 15", it, seq_n);
         end
         for (int k = 0; k < 15; k++) begin
            tests_run++;
            if (seq[k] !== exp_rk(14 - k)) begin
               tests_failed++;
               $display("FAIL roundtrip_%0d_rk%0d: got %h want %h", it, 14 - k, seq[k],
                        exp_rk(14 - k));
            end
         end
      end
   endtask

   task automatic test_start_during_busy();
      logic [255:0] alt;
      int           dones;
      alt = rand_key();
      forward_expand(rand_key());
      run_capture(fw_last(), 10, 53, alt);
      gather();
      tests_run++;
      if (seq_n !== 15) begin
         tests_failed++;
         $display("FAIL busy_start_count: got %0d want 15", seq_n);
      end
      for (int k = 0; k < 15; k++) begin
         tests_run++;
         if (seq[k] !== exp_rk(14 - k)) begin
            tests_failed++;
            $display("FAIL busy_start_rk%0d: got %h want %h", 14 - k, seq[k], exp_rk(14 - k));
         end
      end
      dones = 0;
      for (int n = 1; n <= NCAP; n++) if (cap_done[n] === 1'b1) dones++;
      tests_run++;
      if (dones !== 1 || cap_done[53] !== 1'b1) begin
         tests_failed++;
         $display("FAIL busy_start_done: got %0d pulses want 1 at E53", dones);
      end
      tests_run++;
      if (bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL busy_start_no_rerun: got busy=%b want 0", bus.busy);
      end
      bus.key_last = alt;
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      tests_run++;
      if (bus.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL busy_start_new_run: got busy=%b want 1", bus.busy);
      end
      tick();
      tests_run++;
      if (bus.round_key_valid !== 1'b1 || bus.round_key_out !== alt[127:0]) begin
         tests_failed++;
         $display("FAIL busy_start_new_rk14: got valid=%b key=%h want valid=1 key=%h",
                  bus.round_key_valid, bus.round_key_out, alt[127:0]);
      end
      repeat (54) tick();
   endtask

   task automatic test_reset_mid_run();
      int pulses;
      int busy_seen;
      forward_expand(rand_key());
      bus.key_last = fw_last();
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (19) tick();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.round_key_out !== 128'h0 || bus.round_key_valid !== 1'b0 ||
          bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: got rk=%h v=%b busy=%b done=%b want all 0",
                  bus.round_key_out, bus.round_key_valid, bus.busy, bus.done);
      end
      bus.start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.start = 1'b0;
      tests_run++;
      if (bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_start_in_reset: got busy=%b want 0", bus.busy);
      end
      rst_n     = 1'b1;
      pulses    = 0;
      busy_seen = 0;
      for (int n = 0; n < 60; n++) begin
         tick();
         if (bus.round_key_valid === 1'b1) pulses++;
         if (bus.busy === 1'b1) busy_seen++;
      end
      tests_run++;
      if (pulses !== 0 || busy_seen !== 0) begin
         tests_failed++;
         $display("FAIL midreset_quiet: got %0d pulses, %0d busy cycles want 0", pulses,
                  busy_seen);
      end
      forward_expand(rand_key());
      run_capture(fw_last(), 0, 0, '0);
      gather();
      tests_run++;
      if (seq_n !== 15) begin
         tests_failed++;
         $display("FAIL midreset_rerun_count: got %0d want 15", seq_n);
      end
      for (int k = 0; k < 15; k++) begin
         tests_run++;
         if (seq[k] !== exp_rk(14 - k)) begin
            tests_failed++;
            $display("FAIL midreset_rerun_rk%0d: got %h want %h", 14 - k, seq[k],
                     exp_rk(14 - k));
         end
      end
   endtask

   initial begin
      test_reset();
      test_fips_c3();
      test_timing();
      test_round_trip();
      test_start_during_busy();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/inv_roundkeygen.md
INV_ROUNDKEYGEN -- requirements
Module: inv_roundkeygen

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: key_last  input  256  AES-256 final expanded words {w52,w53,...,w59}; w52 in [255:224].
REQ-004 SHALL have port: start  input  1  begin inverse expansion; sampled only when busy=0.
REQ-005 SHALL have port: round_key_out  output  128  current round key {w4r,w4r+1,w4r+2,w4r+3}.
REQ-006 SHALL have port: round_key_valid  output  1  one-cycle pulse; round_key_out holds a new round key.
REQ-007 SHALL have port: busy  output  1  high while expansion is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse coincident with the round-key-0 output.

Function
REQ-009 SHALL hold an 8-word window buf[0..7] = w[i..i+7], with i = 52 after load.
REQ-010 SHALL run FSM states IDLE and EXPAND; IDLE->EXPAND on start while busy=0; EXPAND->IDLE on the edge that outputs round key 0.
REQ-011 SHALL, on the start edge E0, load buf from key_last, set i=52, and set busy=1.
REQ-012 SHALL derive one word per EXPAND edge (E1..E52): w[i-1] = buf[7] XOR f(buf[6]), where j = i+7.
REQ-013 SHALL define f: j mod 8 = 0 -> SubWord(RotWord(x)) XOR Rcon[j/8]; j mod 8 = 4 -> SubWord(x); otherwise x.
REQ-014 SHALL implement RotWord(x) = {x[23:0], x[31:24]}.
REQ-015 SHALL implement SubWord as the team sbox applied to each byte (4 combinational lookups).
REQ-016 SHALL use Rcon[1..7] = 01,02,04,08,10,20,40 in byte [31:24], zero elsewhere.
REQ-017 SHALL shift the window right on each derived word (buf[k+1]<=buf[k], buf[0]<=new word) and decrement i.
REQ-018 SHALL register outputs so that RK14={w56..w59} appears at E1 and RK13={w52..w55} appears at E2.
REQ-019 SHALL output RK r for r=12..0 at edge E(4*(13-r)+1), taken from buf[0..3] after w[4r] is derived.
REQ-020 SHALL pulse round_key_valid exactly 15 times per run (E1, E2, E5, E9, ..., E53), in descending round order.
REQ-021 SHALL hold round_key_out between pulses; round_key_valid=0 on all other cycles.
REQ-022 SHALL assert done together with RK0 at E53; SHALL drop busy at E53.
REQ-023 SHALL ignore start while busy=1, including the E53 cycle; start is accepted at the first edge with busy=0.
REQ-024 SHALL not derive words below w0 (exactly 52 derivations per run).

Reset
REQ-025 SHALL, on rst_n=0 and regardless of clock, clear buf, the counter, round_key_out, round_key_valid, busy and done to 0 and enter IDLE.
REQ-026 SHALL abandon a run when reset is asserted mid-EXPAND, with no further valid pulses until a new start.
REQ-027 SHALL ignore start while rst_n=0, and sample start on the first clock edge after rst_n is released.

Verification
REQ-028 SHALL be verified for the FIPS-197 C.3 vector: key_last = 4e5a6699a9f24fe07e572baacdf8cdea_24fc79ccbf0979e9371ac23c6d68de36 -> E1 = 24fc79cc...de36; E2 = 4e5a6699...cdea; E49 = 101112131415161718191a1b1c1d1e1f; E53 = 000102030405060708090a0b0c0d0e0f with done=1.
REQ-029 SHALL be verified by round-trip: 20 random 256-bit keys through forward expansion to w52..w59, fed to this block -> the 15 outputs equal the forward round keys in reverse order.
REQ-030 SHALL be verified for timing: exactly 15 valid pulses at E1, E2, E5, ..., E53; busy=1 from E0 through E52; done only at E53.
REQ-031 SHALL be verified for start during busy: start pulsed at E10 and at E53 -> output sequence unchanged; a new run begins only on a start sampled with busy=0.
REQ-032 SHALL be verified for reset mid-run: rst_n low at E20 -> all outputs 0 immediately and no pulses afterwards; then start -> a full correct 15-key run.
